distance_filter_alert: RTL and testbench

Downstream consumer of the ultrasonic sensor driver's 8-bit distance (cm) output. Smooths raw samples with a power-of-two moving average held in a ring buffer. Drives a debounced, hysteretic proximity alert from the averaged value. Flags a stale sensor when no valid sample arrives within a timeout.

---
 rtl/distance_filter_alert_if.sv | 24 ++
 rtl/distance_filter_alert.sv | 185 ++++++++++++++++++
 tb/tb_distance_filter_alert.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/distance_filter_alert_if.sv
// Sample/average bus between the ultrasonic distance source and the filter.
//   master : drives sample_valid/sample_cm, observes the filtered results.
//   slave  : the filter; consumes samples, drives avg_valid, avg_cm, alert, stale, fill_count.
interface distance_filter_alert_if #(
  parameter int unsigned DEPTH_LOG2 = 2
) ();
  logic                  sample_valid;
  logic [7:0]            sample_cm;
  logic                  avg_valid;
  logic [7:0]            avg_cm;
  logic                  alert;
  logic                  stale;
  logic [DEPTH_LOG2:0]   fill_count;

  modport master (
    output sample_valid, sample_cm,
    input  avg_valid, avg_cm, alert, stale, fill_count
  );

  modport slave (
    input  sample_valid, sample_cm,
    output avg_valid, avg_cm, alert, stale, fill_count
  );
endinterface

// File: rtl/distance_filter_alert.sv
// Distance filter with proximity alert and stale-sensor detection.
// Smooths accepted 8-bit distance samples with a 2**DEPTH_LOG2 moving average, drives a debounced
// hysteretic alert from the average and flags the sensor stale after TIMEOUT_CYCLES without an
// accepted sample (which also flushes the window and clears the alert).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave modport; sample_valid/sample_cm in, avg_valid/avg_cm/alert/stale/fill_count out
module distance_filter_alert #(
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter int unsigned NEAR_CM        = 80,
  parameter int unsigned FAR_CM         = 90,
  parameter int unsigned CONFIRM        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input logic                   clk,
  input logic                   rst,
  distance_filter_alert_if.slave bus
);

  localparam int unsigned N  = 2 ** DEPTH_LOG2;
  localparam int unsigned SW = 8 + DEPTH_LOG2;
  localparam int unsigned FW = DEPTH_LOG2 + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [FW-1:0] FillMax    = FW'(N);
  localparam logic [TW-1:0] TimerLast  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    NearCm     = 8'(NEAR_CM);
  localparam logic [7:0]    FarCm      = 8'(FAR_CM);
  localparam logic [3:0]    ConfirmCnt = 4'(CONFIRM);

  typedef enum logic [1:0] {StSafe, StNearPend, StNear, StSafePend} state_e;

  logic [7:0]            win_q [N];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FW-1:0]         fill_q;
  logic [SW-1:0]         sum_q;
  logic [7:0]            avg_q;
  logic                  avg_valid_q;
  logic                  alert_q;
  logic                  stale_q;
  logic [TW-1:0]         timer_q;
  logic [3:0]            cnt_q;
  state_e                state_q;

  logic          accept;
  logic          full;
  logic          timeout;
  logic [SW-1:0] sum_d;
  logic [FW-1:0] fill_d;
  logic [3:0]    cnt_inc;

  always_comb begin
    accept  = bus.sample_valid && (bus.sample_cm != 8'd0);
    full    = (fill_q == FillMax);
    // An accept on the timeout edge takes priority, so only flag timeout when idle.
    timeout = !accept && (timer_q == TimerLast);
    // Modulo arithmetic is exact here: the true result always fits in SW bits.
    sum_d   = sum_q + SW'(bus.sample_cm);
    if (full) begin
      sum_d = sum_d - SW'(win_q[wr_ptr_q]);
    end
    fill_d  = full ? fill_q : fill_q + FW'(1);
    cnt_inc = cnt_q + 4'd1;
  end

  // Window storage needs no reset: entries are only read once fill_count says they are valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q[wr_ptr_q] <= bus.sample_cm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alert_q     <= 1'b0;
      stale_q     <= 1'b0;
      timer_q     <= '0;
      cnt_q       <= '0;
      state_q     <= StSafe;
    end else begin
      avg_valid_q <= 1'b0;

      // Window, average and stale timer.
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q   <= fill_d;
        sum_q    <= sum_d;
        timer_q  <= '0;
        stale_q  <= 1'b0;
        if (fill_d == FillMax) begin
          avg_valid_q <= 1'b1;
          avg_q       <= sum_d[SW-1:DEPTH_LOG2];
        end
      end else if (timeout) begin
        // Timer saturates here; the flush simply repeats until the next accept.
        stale_q  <= 1'b1;
        fill_q   <= '0;
        sum_q    <= '0;
        wr_ptr_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      // Alert FSM: steps once per new average, forced safe on timeout.
      if (timeout) begin
        state_q <= StSafe;
        alert_q <= 1'b0;
        cnt_q   <= '0;
      end else if (avg_valid_q) begin
        unique case (state_q)
          StSafe: begin
            if (avg_q < NearCm) begin
              if (ConfirmCnt == 4'd1) begin
                state_q <= StNear;
                alert_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                state_q <= StNearPend;
                cnt_q   <= 4'd1;
              end
            end
          end
          StNearPend: begin
            if (avg_q < NearCm) begin
              if (cnt_inc == ConfirmCnt) begin
                state_q <= StNear;
                alert_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StSafe;
              cnt_q   <= '0;
            end
          end
          StNear: begin
            if (avg_q >= FarCm) begin
              if (ConfirmCnt == 4'd1) begin
                state_q <= StSafe;
                alert_q <= 1'b0;
                cnt_q   <= '0;
              end else begin
                state_q <= StSafePend;
                cnt_q   <= 4'd1;
              end
            end
          end
          StSafePend: begin
            if (avg_q >= FarCm) begin
              if (cnt_inc == ConfirmCnt) begin
                state_q <= StSafe;
                alert_q <= 1'b0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= StNear;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= StSafe;
            alert_q <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.avg_valid  = avg_valid_q;
  assign bus.avg_cm     = avg_q;
  assign bus.alert      = alert_q;
  assign bus.stale      = stale_q;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_distance_filter_alert.sv
// Directed bench for distance_filter_alert (window 4, NEAR 80, FAR 90, CONFIRM 3, timeout 100).
module tb_distance_filter_alert;

  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  distance_filter_alert_if #(.DEPTH_LOG2(2)) bus ();

  distance_filter_alert #(
    .DEPTH_LOG2(2), .NEAR_CM(80), .FAR_CM(90), .CONFIRM(3), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One sample strobe; returns outputs just after the accepting edge and alert one edge later.
  task automatic send(input logic [7:0] v, output logic av, output logic [7:0] ac,
                      output logic [2:0] fc, output logic al);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_cm    = v;
    @(posedge clk);
    #1;
    av = bus.avg_valid;
    ac = bus.avg_cm;
    fc = bus.fill_count;
    bus.sample_valid = 1'b0;
    bus.sample_cm    = 8'd0;
    @(posedge clk);
    #1;
    al = bus.alert;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_cm    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid got %b want 0", bus.avg_valid); end
    checks++; if (bus.avg_cm !== 8'd0) begin errors++; $display("FAIL reset_avg_cm got %0d want 0", bus.avg_cm); end
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL reset_alert got %b want 0", bus.alert); end
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL reset_stale got %b want 0", bus.stale); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", bus.fill_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_warmup();
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    for (int i = 0; i < 4; i++) begin
      send(8'd100, av, ac, fc, al);
      checks++; if (av !== (i == 3)) begin errors++; $display("FAIL warmup_valid[%0d] got %b want %b", i, av, (i == 3)); end
      checks++; if (fc !== 3'(i + 1)) begin errors++; $display("FAIL warmup_fill[%0d] got %0d want %0d", i, fc, i + 1); end
    end
    checks++; if (ac !== 8'd100) begin errors++; $display("FAIL warmup_avg got %0d want 100", ac); end
    checks++; if (al !== 1'b0) begin errors++; $display("FAIL warmup_alert got %b want 0", al); end
  endtask

  task automatic test_near();
    logic [7:0] ea [6] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd60, 8'd60};
    logic       el [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    for (int i = 0; i < 6; i++) begin
      send(8'd60, av, ac, fc, al);
      checks++; if (av !== 1'b1) begin errors++; $display("FAIL near_valid[%0d] got %b want 1", i, av); end
      checks++; if (ac !== ea[i]) begin errors++; $display("FAIL near_avg[%0d] got %0d want %0d", i, ac, ea[i]); end
      checks++; if (al !== el[i]) begin errors++; $display("FAIL near_alert[%0d] got %b want %b", i, al, el[i]); end
    end
  endtask

  task automatic test_clear();
    logic [7:0] s  [6] = '{8'd160, 8'd100, 8'd20, 8'd100, 8'd160, 8'd100};
    logic [7:0] ea [6] = '{8'd85, 8'd95, 8'd85, 8'd95, 8'd95, 8'd95};
    logic       el [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    for (int i = 0; i < 6; i++) begin
      send(s[i], av, ac, fc, al);
      checks++; if (ac !== ea[i]) begin errors++; $display("FAIL clear_avg[%0d] got %0d want %0d", i, ac, ea[i]); end
      checks++; if (al !== el[i]) begin errors++; $display("FAIL clear_alert[%0d] got %b want %b", i, al, el[i]); end
    end
  endtask

  task automatic test_oscillation();
    logic [7:0] s  [10] = '{8'd80, 8'd80, 8'd80, 8'd80, 8'd76, 8'd88, 8'd72, 8'd88, 8'd68, 8'd96};
    logic [7:0] ea [10] = '{8'd110, 8'd105, 8'd85, 8'd80, 8'd79, 8'd81, 8'd79, 8'd81, 8'd79, 8'd81};
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    for (int i = 0; i < 10; i++) begin
      send(s[i], av, ac, fc, al);
      checks++; if (ac !== ea[i]) begin errors++; $display("FAIL osc_avg[%0d] got %0d want %0d", i, ac, ea[i]); end
      checks++; if (al !== 1'b0) begin errors++; $display("FAIL osc_alert[%0d] got %b want 0", i, al); end
    end
  endtask

  task automatic test_stale();
    logic [7:0] ea [4] = '{8'd75, 8'd66, 8'd61, 8'd50};
    logic       el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    for (int i = 0; i < 4; i++) begin
      send(8'd50, av, ac, fc, al);
      checks++; if (ac !== ea[i]) begin errors++; $display("FAIL stale_pre_avg[%0d] got %0d want %0d", i, ac, ea[i]); end
      checks++; if (al !== el[i]) begin errors++; $display("FAIL stale_pre_alert[%0d] got %b want %b", i, al, el[i]); end
    end
    // Zero samples are dropped and must not restart the timer.
    for (int i = 0; i < 3; i++) begin
      send(8'd0, av, ac, fc, al);
      checks++; if (av !== 1'b0) begin errors++; $display("FAIL zero_valid[%0d] got %b want 0", i, av); end
      checks++; if (fc !== 3'd4) begin errors++; $display("FAIL zero_fill[%0d] got %0d want 4", i, fc); end
    end
    // Last accept was 7 edges ago; stale lands exactly TO edges after it.
    repeat (TO - 8) @(posedge clk);
    #1;
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_early got %b want 0", bus.stale); end
    @(posedge clk);
    #1;
    checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_set got %b want 1", bus.stale); end
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL stale_alert got %b want 0", bus.alert); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL stale_fill got %0d want 0", bus.fill_count); end
    for (int i = 0; i < 4; i++) begin
      send(8'd40, av, ac, fc, al);
      checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_clear[%0d] got %b want 0", i, bus.stale); end
      checks++; if (av !== (i == 3)) begin errors++; $display("FAIL rewarm_valid[%0d] got %b want %b", i, av, (i == 3)); end
      checks++; if (fc !== 3'(i + 1)) begin errors++; $display("FAIL rewarm_fill[%0d] got %0d want %0d", i, fc, i + 1); end
    end
    checks++; if (ac !== 8'd40) begin errors++; $display("FAIL rewarm_avg got %0d want 40", ac); end
  endtask

  task automatic test_timeout_edge();
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    // Last accept was 1 edge ago; land the next accept on edge TO after it.
    repeat (TO - 2) @(posedge clk);
    #1;
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL edge_pre_stale got %b want 0", bus.stale); end
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_cm    = 8'd30;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL edge_stale got %b want 0", bus.stale); end
    checks++; if (bus.avg_valid !== 1'b1) begin errors++; $display("FAIL edge_valid got %b want 1", bus.avg_valid); end
    checks++; if (bus.avg_cm !== 8'd37) begin errors++; $display("FAIL edge_avg got %0d want 37", bus.avg_cm); end
    checks++; if (bus.fill_count !== 3'd4) begin errors++; $display("FAIL edge_fill got %0d want 4", bus.fill_count); end
    @(posedge clk);
    #1;
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL edge_post_stale got %b want 0", bus.stale); end
    send(8'd30, av, ac, fc, al);
    checks++; if (ac !== 8'd35) begin errors++; $display("FAIL edge_avg2 got %0d want 35", ac); end
    checks++; if (al !== 1'b1) begin errors++; $display("FAIL edge_alert got %b want 1", al); end
  endtask

  task automatic test_mid_reset();
    logic av, al;
    logic [7:0] ac;
    logic [2:0] fc;
    @(negedge clk);
    rst = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_cm    = 8'd10;
    @(posedge clk);
    #1;
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.avg_valid); end
    checks++; if (bus.avg_cm !== 8'd0) begin errors++; $display("FAIL mid_avg got %0d want 0", bus.avg_cm); end
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL mid_alert got %b want 0", bus.alert); end
    checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", bus.stale); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL mid_fill got %0d want 0", bus.fill_count); end
    @(negedge clk);
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    send(8'd200, av, ac, fc, al);
    send(8'd200, av, ac, fc, al);
    checks++; if (fc !== 3'd2) begin errors++; $display("FAIL mid_part_fill got %0d want 2", fc); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL mid_fill2 got %0d want 0", bus.fill_count); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'd50, av, ac, fc, al);
      checks++; if (av !== (i == 3)) begin errors++; $display("FAIL post_valid[%0d] got %b want %b", i, av, (i == 3)); end
    end
    checks++; if (ac !== 8'd50) begin errors++; $display("FAIL post_avg got %0d want 50", ac); end
    checks++; if (al !== 1'b0) begin errors++; $display("FAIL post_alert got %b want 0", al); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s  [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [7:0] ea [4] = '{8'd40, 8'd32, 8'd27, 8'd25};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_cm    = s[i];
      @(posedge clk);
      #1;
      checks++; if (bus.avg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, bus.avg_valid); end
      checks++; if (bus.avg_cm !== ea[i]) begin errors++; $display("FAIL b2b_avg[%0d] got %0d want %0d", i, bus.avg_cm, ea[i]); end
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.avg_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.avg_valid); end
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL b2b_alert got %b want 1", bus.alert); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_near();
    test_clear();
    test_oscillation();
    test_stale();
    test_timeout_edge();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
